// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment pattern engine.
// No logic; imported by the engine and its testbench.
package seg7_pkg;

   typedef enum logic [1:0] {
      MODE_HEX    = 2'd0,
      MODE_BCD    = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_MSG    = 2'd3
   } mode_e;

   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/seg7_pattern_engine_if.sv
// Message-buffer write port: nibble append with ready, plus a buffer clear.
// wr_ready is combinational from the stored length; a write without ready is dropped.
interface seg7_pattern_engine_if;
   logic       wr_valid;
   logic [3:0] wr_nibble;
   logic       wr_ready;
   logic       wr_clear;

   modport master (output wr_valid, output wr_nibble, output wr_clear, input wr_ready);
   modport slave  (input wr_valid, input wr_nibble, input wr_clear, output wr_ready);
endinterface

// File: rtl/seg7_tick_divider.sv
// Free-running 2^DIV_W divider; tick is high while the counter is all-ones (no latency, no stall).
// Never backpressured: it keeps counting regardless of hold or mode.
module seg7_tick_divider #(
   parameter int DIV_W = 22
) (
   input  logic clock,
   input  logic reset_n,
   output logic tick
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt + DIV_W'(1);
   end

   assign tick = &cnt;

endmodule

// File: rtl/seg7_pattern_engine.sv
// Display content source (hex/BCD count, bounce, scrolling message); number/dots feed seven_segment_display as-is.
// Content moves 1 clock after each unheld tick; buffer writes drop while full, clear beats a same-cycle write.
module seg7_pattern_engine
   import seg7_pkg::*;
#(
   parameter int W_DIGITS  = 8,
   parameter int MSG_DEPTH = 16,
   parameter int DIV_W     = 22
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [1:0]                     mode,
   input  logic                           hold,
   input  logic [W_DIGITS-1:0]            key_dots,
   seg7_pattern_engine_if.slave           wr,
   output logic [W_DIGITS*4-1:0]          number,
   output logic [W_DIGITS-1:0]            dots,
   output logic                           tick_out,
   output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len
);

   localparam int LEN_W = $clog2(MSG_DEPTH+1);
   localparam int PTR_W = $clog2(MSG_DEPTH);
   localparam int POS_W = $clog2(W_DIGITS);
   localparam int NUM_W = W_DIGITS*4;

   mode_e               mode_cur;
   mode_e               mode_q;
   logic                mode_chg;
   logic                upd;
   logic                wr_acc;
   logic [3:0]          msg_mem [MSG_DEPTH];
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    ptr_nxt;
   logic [LEN_W-1:0]    len_nxt;
   logic [POS_W-1:0]    pos;
   logic [POS_W-1:0]    pos_nxt;
   logic                dir_up;
   logic                dir_nxt;
   logic [NUM_W-1:0]    num_nxt;
   logic [NUM_W-1:0]    msg_view;
   logic [W_DIGITS-1:0] dots_nxt;

   seg7_tick_divider #(.DIV_W(DIV_W)) u_div (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (tick_out)
   );

   assign mode_cur    = mode_e'(mode);
   assign mode_chg    = (mode_cur != mode_q);
   assign upd         = tick_out & ~hold;
   assign wr.wr_ready = (int'(msg_len) < MSG_DEPTH);
   assign wr_acc      = wr.wr_valid & wr.wr_ready & ~wr.wr_clear;

   function automatic logic [NUM_W-1:0] bcd_inc(input logic [NUM_W-1:0] v);
      logic [NUM_W-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < W_DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == BCD_DIGIT_MAX) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Scroll pointer wraps on the length before this cycle's append.
   always_comb begin
      len_nxt = msg_len;
      ptr_nxt = ptr;
      if (wr.wr_clear)  len_nxt = '0;
      else if (wr_acc)  len_nxt = msg_len + LEN_W'(1);
      if (mode_chg || wr.wr_clear) begin
         ptr_nxt = '0;
      end else if (mode_cur == MODE_MSG && upd && msg_len != '0) begin
         ptr_nxt = (int'(ptr) + 1 == int'(msg_len)) ? '0 : ptr + PTR_W'(1);
      end
   end

   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir_up;
      if (mode_chg) begin
         pos_nxt = '0;
         dir_nxt = 1'b1;
      end else if (mode_cur == MODE_BOUNCE && upd) begin
         if (dir_up) begin
            if (int'(pos) == W_DIGITS-1) begin
               pos_nxt = pos - POS_W'(1);
               dir_nxt = 1'b0;
            end else begin
               pos_nxt = pos + POS_W'(1);
            end
         end else begin
            if (pos == '0) begin
               pos_nxt = POS_W'(1);
               dir_nxt = 1'b1;
            end else begin
               pos_nxt = pos - POS_W'(1);
            end
         end
      end
   end

   // Built from next-cycle buffer state so appends and clears show one clock later.
   always_comb begin
      logic [PTR_W-1:0] idx;
      msg_view = '0;
      idx      = ptr_nxt;
      if (len_nxt != '0) begin
         for (int i = 0; i < W_DIGITS; i++) begin
            msg_view[4*(W_DIGITS-1-i) +: 4] =
               (wr_acc && int'(idx) == int'(msg_len)) ? wr.wr_nibble : msg_mem[idx];
            idx = (int'(idx) + 1 == int'(len_nxt)) ? '0 : idx + PTR_W'(1);
         end
      end
   end

   always_comb begin
      num_nxt  = number;
      dots_nxt = key_dots;
      if (mode_chg) begin
         num_nxt = '0;
      end else begin
         case (mode_cur)
            MODE_HEX: if (upd) num_nxt = number + NUM_W'(1);
            MODE_BCD: if (upd) num_nxt = bcd_inc(number);
            MODE_BOUNCE: begin
               num_nxt                        = '0;
               num_nxt[4*int'(pos_nxt) +: 4]  = 4'hF;
               dots_nxt[pos_nxt]              = 1'b1;
            end
            default: num_nxt = msg_view;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_q  <= MODE_HEX;
         number  <= '0;
         dots    <= '0;
         msg_len <= '0;
         ptr     <= '0;
         pos     <= '0;
         dir_up  <= 1'b1;
      end else begin
         mode_q  <= mode_cur;
         number  <= num_nxt;
         dots    <= dots_nxt;
         msg_len <= len_nxt;
         ptr     <= ptr_nxt;
         pos     <= pos_nxt;
         dir_up  <= dir_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_acc) msg_mem[msg_len[PTR_W-1:0]] <= wr.wr_nibble;
   end

endmodule
